// File: rtl/fb_read_scheduler.sv
// Frame-buffer read-port arbiter: display reads always win, aux bursts fill idle cycles.
// A tag pipeline matched to the memory latency routes each returned word to its requester.
module fb_read_scheduler #(
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned FB_DEPTH = 76800,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned LEN_W    = 17
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              disp_en_i,
   input  logic [ADDR_W-1:0] disp_addr_i,
   output logic              disp_valid_o,
   output logic [DATA_W-1:0] disp_data_o,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   output logic              aux_valid_o,
   output logic [DATA_W-1:0] aux_data_o,
   output logic              aux_last_o,
   output logic              aux_done_o,
   output logic              busy_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic valid;
      logic owner;
      logic oob;
      logic last;
   } tag_t;

   localparam logic              OWN_DISP = 1'b0;
   localparam logic              OWN_AUX  = 1'b1;
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(FB_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(FB_DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic                burst_oob_q, burst_oob_d;
   logic                zero_done_q, zero_done_d;
   tag_t                pipe_q [RD_LAT];
   tag_t                issue_tag;
   tag_t                exit_tag;
   logic                disp_in_range;
   logic                drain_done;
   logic                disp_hit;
   logic                aux_hit;

   assign disp_in_range = (disp_addr_i < DEPTH_A);
   assign exit_tag      = pipe_q[RD_LAT-1];
   assign disp_hit      = exit_tag.valid && (exit_tag.owner == OWN_DISP);
   assign aux_hit       = exit_tag.valid && (exit_tag.owner == OWN_AUX);

   // Issue arbitration and burst FSM next-state
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      burst_oob_d = burst_oob_q;
      zero_done_d = 1'b0;
      issue_tag   = '0;
      mem_en_o    = 1'b0;
      mem_addr_o  = '0;
      cmd_ready_o = 1'b0;
      drain_done  = 1'b0;

      if (!reset_i && disp_en_i) begin
         mem_addr_o = disp_addr_i;
         mem_en_o   = disp_in_range;
         issue_tag  = tag_t'{valid: 1'b1, owner: OWN_DISP, oob: !disp_in_range, last: 1'b0};
      end else if (!reset_i && (state_q == ST_RUN)) begin
         mem_addr_o  = cur_addr_q;
         mem_en_o    = !burst_oob_q;
         issue_tag   = tag_t'{valid: 1'b1, owner: OWN_AUX, oob: burst_oob_q,
                              last: (remaining_q == LEN_W'(1))};
         cur_addr_d  = (cur_addr_q == LAST_A) ? '0 : cur_addr_q + ADDR_W'(1);
         remaining_d = remaining_q - LEN_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               if (cmd_len_i != '0) begin
                  cur_addr_d  = cmd_addr_i;
                  remaining_d = cmd_len_i;
                  burst_oob_d = (cmd_addr_i >= DEPTH_A);
                  state_d     = ST_RUN;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (issue_tag.valid && (issue_tag.owner == OWN_AUX) && issue_tag.last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (aux_hit && exit_tag.last) begin
               drain_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, burst counters and tag pipeline
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         burst_oob_q <= 1'b0;
         zero_done_q <= 1'b0;
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         burst_oob_q <= burst_oob_d;
         zero_done_q <= zero_done_d;
         pipe_q[0]   <= issue_tag;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // Return routing; out-of-range words come back as zero
   assign disp_valid_o = disp_hit;
   assign disp_data_o  = (disp_hit && !exit_tag.oob) ? mem_rdata_i : '0;
   assign aux_valid_o  = aux_hit;
   assign aux_data_o   = (aux_hit && !exit_tag.oob) ? mem_rdata_i : '0;
   assign aux_last_o   = aux_hit && exit_tag.last;
   assign aux_done_o   = zero_done_q || drain_done;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Self-checking bench for fb_read_scheduler: directed vector table plus
// display sweep and display-stall sequences against a behavioural memory.
module tb_fb_read_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_en;
   logic [16:0] disp_addr;
   logic        disp_valid;
   logic [15:0] disp_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [16:0] cmd_addr;
   logic [16:0] cmd_len;
   logic        aux_valid;
   logic [15:0] aux_data;
   logic        aux_last;
   logic        aux_done;
   logic        busy;
   logic        mem_en;
   logic [16:0] mem_addr;
   logic [15:0] mem_rdata = 16'h0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fb_read_scheduler dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .disp_en_i   (disp_en),
      .disp_addr_i (disp_addr),
      .disp_valid_o(disp_valid),
      .disp_data_o (disp_data),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_addr_i  (cmd_addr),
      .cmd_len_i   (cmd_len),
      .aux_valid_o (aux_valid),
      .aux_data_o  (aux_data),
      .aux_last_o  (aux_last),
      .aux_done_o  (aux_done),
      .busy_o      (busy),
      .mem_en_o    (mem_en),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata)
   );

   function automatic logic [15:0] pix(input logic [16:0] a);
      return 16'(a * 7) ^ 16'h3C5A;
   endfunction

   // Frame-buffer model, latency 1; garbage when not enabled
   always @(posedge clk) begin
      mem_rdata <= mem_en ? pix(mem_addr) : 16'hDEAD;
   end

   typedef struct packed {
      logic        rst;
      logic        de;
      logic [16:0] da;
      logic        cv;
      logic [16:0] ca;
      logic [16:0] cl;
      logic        rdy;
      logic        bsy;
      logic        men;
      logic [16:0] maddr;
      logic        dv;
      logic [16:0] dra;
      logic        dz;
      logic        av;
      logic [16:0] ara;
      logic        az;
      logic        al;
      logic        ad;
   } vec_t;

   function automatic vec_t V(
      input logic rst, input logic de, input logic [16:0] da,
      input logic cv, input logic [16:0] ca, input logic [16:0] cl,
      input logic rdy, input logic bsy, input logic men, input logic [16:0] maddr,
      input logic dv, input logic [16:0] dra, input logic dz,
      input logic av, input logic [16:0] ara, input logic az,
      input logic al, input logic ad);
      vec_t v;
      v.rst = rst; v.de = de; v.da = da; v.cv = cv; v.ca = ca; v.cl = cl;
      v.rdy = rdy; v.bsy = bsy; v.men = men; v.maddr = maddr;
      v.dv = dv; v.dra = dra; v.dz = dz;
      v.av = av; v.ara = ara; v.az = az; v.al = al; v.ad = ad;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      logic [55:0] act;
      logic [55:0] exp;
      logic [15:0] ed;
      logic [15:0] ea;
      @(posedge clk); #1;
      reset     = v.rst;
      disp_en   = v.de;
      disp_addr = v.da;
      cmd_valid = v.cv;
      cmd_addr  = v.ca;
      cmd_len   = v.cl;
      @(negedge clk);
      ed  = (v.dv && !v.dz) ? pix(v.dra) : 16'h0;
      ea  = (v.av && !v.az) ? pix(v.ara) : 16'h0;
      exp = {v.rdy, v.bsy, v.men, v.maddr, v.dv, ed, v.av, ea, v.al, v.ad};
      act = {cmd_ready, busy, mem_en, mem_addr, disp_valid, disp_data,
             aux_valid, aux_data, aux_last, aux_done};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL vec[%0d] rdy/bsy/men/maddr/dv/dd/av/ad/al/done got=%h want=%h",
                  idx, act, exp);
      end
   endtask

   vec_t tbl[$];

   initial begin
      logic [15:0] got[$];
      int          last_idx;
      bit          done_seen;
      vec_t        idle;

      reset = 1'b1; disp_en = 1'b0; disp_addr = '0;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (3) @(posedge clk);

      idle = V(0,0,0,0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0,0);
      apply(idle, -1);

      // Display sweep over one line: each word returns one cycle later
      for (int a = 0; a <= 320; a++) begin
         logic [36:0] dact, dexp;
         @(posedge clk); #1;
         disp_en   = (a < 320);
         disp_addr = (a < 320) ? 17'(a) : 17'h0;
         @(negedge clk);
         dexp = {(a < 320), ((a < 320) ? 17'(a) : 17'h0), (a > 0),
                 ((a > 0) ? pix(17'(a - 1)) : 16'h0), 1'b0};
         dact = {mem_en, mem_addr, disp_valid, disp_data, aux_valid};
         checks++;
         if (dact !== dexp) begin
            failures++;
            $display("FAIL disp_sweep[%0d] got=%h want=%h", a, dact, dexp);
         end
      end

      // Idle burst: addr 100, len 4
      tbl.push_back(V(0,0,0,1,100,4,     1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,100,   0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,101,   0,0,0, 1,100,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,102,   0,0,0, 1,101,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,103,   0,0,0, 1,102,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,0,0,     0,0,0, 1,103,0,1,1));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      // Contention: len 3, display on alternate cycles, stray command ignored
      tbl.push_back(V(0,0,0,1,200,3,     1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,1,10,0,0,0,      0,1,1,10,    0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,200,   1,10,0, 0,0,0,0,0));
      tbl.push_back(V(0,1,11,1,999,5,    0,1,1,11,    0,0,0, 1,200,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,201,   1,11,0, 0,0,0,0,0));
      tbl.push_back(V(0,1,12,0,0,0,      0,1,1,12,    0,0,0, 1,201,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,202,   1,12,0, 0,0,0,0,0));
      tbl.push_back(V(0,1,13,0,0,0,      0,1,1,13,    0,0,0, 1,202,0,1,1));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     1,13,0, 0,0,0,0,0));
      // Address wrap at end of frame
      tbl.push_back(V(0,0,0,1,76798,4,   1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,76798, 0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,76799, 0,0,0, 1,76798,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,0,     0,0,0, 1,76799,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,1,     0,0,0, 1,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,0,0,     0,0,0, 1,1,0,1,1));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      // Out-of-range burst: no memory enables, zero words
      tbl.push_back(V(0,0,0,1,80000,2,   1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,0,80000, 0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,0,80001, 0,0,0, 1,0,1,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,0,0,     0,0,0, 1,0,1,1,1));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      // Display just past and at the last valid address
      tbl.push_back(V(0,1,76800,0,0,0,   1,0,0,76800, 0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,1,76799,0,0,0,   1,0,1,76799, 1,76800,1, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     1,76799,0, 0,0,0,0,0));
      // Zero-length command
      tbl.push_back(V(0,0,0,1,5,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,1));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      // Reset after three issues of a len-8 burst, then a fresh burst
      tbl.push_back(V(0,0,0,1,300,8,     1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,300,   0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,301,   0,0,0, 1,300,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,302,   0,0,0, 1,301,0,0,0));
      tbl.push_back(V(1,0,0,0,0,0,       0,1,0,0,     0,0,0, 1,302,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,1,10,2,      1,0,0,0,     0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,10,    0,0,0, 0,0,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,1,11,    0,0,0, 1,10,0,0,0));
      tbl.push_back(V(0,0,0,0,0,0,       0,1,0,0,     0,0,0, 1,11,0,1,1));
      tbl.push_back(V(0,0,0,0,0,0,       1,0,0,0,     0,0,0, 0,0,0,0,0));

      foreach (tbl[i]) apply(tbl[i], i);

      // Burst accepted while display holds the port for ten cycles
      @(posedge clk); #1;
      disp_en = 1'b1; disp_addr = 17'd7;
      cmd_valid = 1'b1; cmd_addr = 17'd500; cmd_len = 17'd3;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_accept cmd_ready got=%b want=1", cmd_ready);
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         disp_addr = 17'(20 + k);
         @(negedge clk);
         checks++;
         if ({mem_en, mem_addr, busy, aux_valid} !== {1'b1, 17'(20 + k), 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL stall[%0d] men=%b maddr=%0d busy=%b av=%b want men=1 maddr=%0d busy=1 av=0",
                     k, mem_en, mem_addr, busy, aux_valid, 20 + k);
         end
      end
      @(posedge clk); #1;
      disp_en = 1'b0; disp_addr = '0;
      done_seen = 1'b0;
      last_idx  = -1;
      for (int c = 0; c < 20 && !done_seen; c++) begin
         @(negedge clk);
         if (aux_valid) begin
            got.push_back(aux_data);
            if (aux_last) last_idx = got.size() - 1;
         end
         if (aux_done) done_seen = 1'b1;
         else @(posedge clk);
      end
      checks++;
      if (!done_seen) begin
         failures++;
         $display("FAIL stall_done timeout got_words=%0d want aux_done within 20 cycles", got.size());
      end
      checks++;
      if (got.size() != 3 || last_idx != 2) begin
         failures++;
         $display("FAIL stall_count words=%0d last_at=%0d want words=3 last_at=2", got.size(), last_idx);
      end else begin
         for (int w = 0; w < 3; w++) begin
            checks++;
            if (got[w] !== pix(17'(500 + w))) begin
               failures++;
               $display("FAIL stall_data[%0d] got=%h want=%h", w, got[w], pix(17'(500 + w)));
            end
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({busy, cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL stall_idle busy=%b cmd_ready=%b want busy=0 cmd_ready=1", busy, cmd_ready);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
